// File: rtl/ctrl_unit_ext_if.sv
// Bus between the extended control unit and the Enhanced Processor datapath:
// status/opcode inputs to the controller and the strobes it drives back.
interface ctrl_unit_ext_if #(
    parameter int STATE_W = 4
);
    logic               Enter;
    logic [3:0]         IR;
    logic               Aeq0;
    logic               Apos;

    logic               IRload;
    logic               JMPmux;
    logic               PCload;
    logic               Meminst;
    logic               MemWr;
    logic [1:0]         Asel;
    logic               Aload;
    logic [2:0]         ALUop;
    logic               Sub;
    logic               Outload;
    logic               Halt;
    logic [STATE_W-1:0] DisplayState;

    // Controller side: samples status and opcode, drives the datapath strobes.
    modport master (
        input  Enter, IR, Aeq0, Apos,
        output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload,
               ALUop, Sub, Outload, Halt, DisplayState
    );

    // Datapath side: supplies status and opcode, receives the strobes.
    modport slave (
        output Enter, IR, Aeq0, Apos,
        input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload,
               ALUop, Sub, Outload, Halt, DisplayState
    );
endinterface

// File: rtl/ctrl_unit_ext.sv
// Control FSM for the Enhanced Processor: 16-opcode decode, memory wait-states,
// multi-op ALU select, output-register load and edge/level Enter handling.
module ctrl_unit_ext #(
    parameter int MEM_WAIT   = 1,
    parameter int ENTER_EDGE = 1,
    parameter int STATE_W    = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    ctrl_unit_ext_if.master  bus
);

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ALU    = 4'd5,
        S_INPUT  = 4'd6,
        S_JUMP   = 4'd7,
        S_OUTPUT = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_WAIT);

    state_t     state, state_next;
    logic [3:0] wcnt;
    logic [3:0] op_q;
    logic       enter_q;
    logic       mem_last;
    logic       enter_done;
    logic       jump_taken;

    logic       ir_load, jmp_mux, pc_load, mem_inst, mem_wr, a_load, out_load, halt;
    logic [1:0] a_sel;
    logic [2:0] alu_op;

    assign mem_last   = (wcnt == LAST_WAIT);
    // enter_q resets high so a button held through reset release never counts as a press.
    assign enter_done = (ENTER_EDGE != 0) ? (bus.Enter & ~enter_q) : bus.Enter;
    assign jump_taken = (bus.IR == 4'h8)
                      | ((bus.IR == 4'h5) &  bus.Aeq0)
                      | ((bus.IR == 4'h6) &  bus.Apos)
                      | ((bus.IR == 4'h9) & ~bus.Aeq0);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= S_START;
            wcnt    <= 4'd0;
            enter_q <= 1'b1;
            op_q    <= 4'd0;
        end else begin
            state   <= state_next;
            enter_q <= bus.Enter;
            if (state == S_DECODE)
                op_q <= bus.IR;
            if (state_next != state)
                wcnt <= 4'd0;
            else if (wcnt != 4'hF)
                wcnt <= wcnt + 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        ir_load    = 1'b0;
        jmp_mux    = 1'b0;
        pc_load    = 1'b0;
        mem_inst   = 1'b0;
        mem_wr     = 1'b0;
        a_sel      = 2'b00;
        a_load     = 1'b0;
        alu_op     = 3'b000;
        out_load   = 1'b0;
        halt       = 1'b0;

        case (state)
            S_START: state_next = S_FETCH;
            S_FETCH: begin
                if (mem_last) begin
                    ir_load    = 1'b1;
                    pc_load    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                mem_inst = 1'b1;
                case (bus.IR)
                    4'h0:                      state_next = S_LOAD;
                    4'h1:                      state_next = S_STORE;
                    4'h2, 4'h3, 4'hA, 4'hB,
                    4'hC, 4'hD:                state_next = S_ALU;
                    4'h4:                      state_next = S_INPUT;
                    4'h7:                      state_next = S_HALT;
                    4'hE:                      state_next = S_OUTPUT;
                    default:                   state_next = jump_taken ? S_JUMP : S_FETCH;
                endcase
            end
            S_LOAD: begin
                mem_inst = 1'b1;
                a_sel    = 2'b10;
                if (mem_last) begin
                    a_load     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_STORE: begin
                mem_inst = 1'b1;
                mem_wr   = 1'b1;
                if (mem_last)
                    state_next = S_FETCH;
            end
            S_ALU: begin
                a_load     = 1'b1;
                state_next = S_FETCH;
                case (op_q)
                    4'h3:    alu_op = 3'b001;
                    4'hA:    alu_op = 3'b010;
                    4'hB:    alu_op = 3'b011;
                    4'hC:    alu_op = 3'b100;
                    4'hD:    alu_op = 3'b101;
                    default: alu_op = 3'b000;
                endcase
            end
            S_INPUT: begin
                a_sel = 2'b01;
                if (enter_done) begin
                    a_load     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_JUMP: begin
                jmp_mux    = 1'b1;
                pc_load    = 1'b1;
                state_next = S_FETCH;
            end
            S_OUTPUT: begin
                out_load   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  halt       = 1'b1;
            default: state_next = S_START;
        endcase
    end

    assign bus.IRload       = ir_load;
    assign bus.JMPmux       = jmp_mux;
    assign bus.PCload       = pc_load;
    assign bus.Meminst      = mem_inst;
    assign bus.MemWr        = mem_wr;
    assign bus.Asel         = a_sel;
    assign bus.Aload        = a_load;
    assign bus.ALUop        = alu_op;
    assign bus.Sub          = (alu_op == 3'b001);
    assign bus.Outload      = out_load;
    assign bus.Halt         = halt;
    assign bus.DisplayState = STATE_W'(state);

endmodule

// File: tb/tb_ctrl_unit_ext.sv
// Self-checking bench for ctrl_unit_ext: directed instruction sequences followed by
// random opcodes, each checked cycle by cycle against an instruction-level model.
module tb_ctrl_unit_ext;

    localparam int MW = 1;

    localparam logic [13:0] B_IRLOAD  = 14'b1 << 13;
    localparam logic [13:0] B_JMPMUX  = 14'b1 << 12;
    localparam logic [13:0] B_PCLOAD  = 14'b1 << 11;
    localparam logic [13:0] B_MEMINST = 14'b1 << 10;
    localparam logic [13:0] B_MEMWR   = 14'b1 << 9;
    localparam logic [13:0] B_ALOAD   = 14'b1 << 6;
    localparam logic [13:0] B_SUB     = 14'b1 << 2;
    localparam logic [13:0] B_OUTLOAD = 14'b1 << 1;
    localparam logic [13:0] B_HALT    = 14'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    logic prevEnter = 1'b1;

    always #5 clk = ~clk;

    ctrl_unit_ext_if #(.STATE_W(4)) bus ();

    ctrl_unit_ext #(.MEM_WAIT(MW), .ENTER_EDGE(1), .STATE_W(4)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    function automatic logic [13:0] aselBits(input logic [1:0] a);
        return {5'b0, a, 7'b0};
    endfunction

    function automatic logic [13:0] aluBits(input logic [2:0] u);
        return {8'b0, u, 3'b0};
    endfunction

    function automatic logic [13:0] observed();
        return {bus.IRload, bus.JMPmux, bus.PCload, bus.Meminst, bus.MemWr, bus.Asel,
                bus.Aload, bus.ALUop, bus.Sub, bus.Outload, bus.Halt};
    endfunction

    function automatic logic randBit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input string tag, input int expState, input logic [13:0] expOut);
        logic [3:0]  st;
        logic [13:0] ov;
        st = bus.DisplayState;
        ov = observed();
        compared++;
        assert (st === 4'(expState)) else begin
            mismatched++;
            $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, st, expState);
        end
        compared++;
        assert (ov === expOut) else begin
            mismatched++;
            $error("[TB] FAIL %s outputs observed=%b expected=%b", tag, ov, expOut);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] irv, input logic ent, input logic z, input logic p);
        @(negedge clk);
        bus.IR    = irv;
        bus.Enter = ent;
        bus.Aeq0  = z;
        bus.Apos  = p;
        #1;
    endtask

    task automatic stepCheck(input string tag, input logic [3:0] irv, input logic ent,
                             input int expState, input logic [13:0] expOut);
        logic z;
        z = randBit();
        applyStimulus(irv, ent, z, z ? 1'b0 : randBit());
        checkOutput(tag, expState, expOut);
        prevEnter = ent;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset     = 1'b1;
        bus.Enter = randBit();
        @(posedge clk);
        #1;
        checkOutput("reset", 0, 14'b0);
        prevEnter = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("start", 0, 14'b0);
        prevEnter = bus.Enter;
    endtask

    task automatic fetchDecode(input logic [3:0] op, input logic z, input logic p, input bit enterHigh);
        for (int i = 0; i <= MW; i++)
            stepCheck("fetch", op, randBit(), 1, (i == MW) ? (B_IRLOAD | B_PCLOAD) : 14'b0);
        applyStimulus(op, enterHigh ? 1'b1 : randBit(), z, p);
        checkOutput("decode", 2, B_MEMINST);
        prevEnter = bus.Enter;
    endtask

    // flagSel: -1 random, 0 none, 1 Aeq0, 2 Apos
    task automatic doInstr(input logic [3:0] op, input int flagSel, input bit holdEnter);
        logic z, p, ent, done, taken;
        logic [2:0] code;
        int n;
        case (flagSel)
            0:       begin z = 1'b0; p = 1'b0; end
            1:       begin z = 1'b1; p = 1'b0; end
            2:       begin z = 1'b0; p = 1'b1; end
            default: begin z = randBit(); p = z ? 1'b0 : randBit(); end
        endcase
        fetchDecode(op, z, p, holdEnter);
        taken = (op == 4'h8) || (op == 4'h5 && z) || (op == 4'h6 && p) || (op == 4'h9 && !z);
        case (op)
            4'h0: for (int i = 0; i <= MW; i++)
                      stepCheck("load", 4'($urandom), randBit(), 3,
                                B_MEMINST | aselBits(2'b10) | ((i == MW) ? B_ALOAD : 14'b0));
            4'h1: for (int i = 0; i <= MW; i++)
                      stepCheck("store", 4'($urandom), randBit(), 4, B_MEMINST | B_MEMWR);
            4'h2, 4'h3, 4'hA, 4'hB, 4'hC, 4'hD: begin
                case (op)
                    4'h3:    code = 3'b001;
                    4'hA:    code = 3'b010;
                    4'hB:    code = 3'b011;
                    4'hC:    code = 3'b100;
                    4'hD:    code = 3'b101;
                    default: code = 3'b000;
                endcase
                stepCheck("alu", 4'($urandom), randBit(), 5,
                          B_ALOAD | aluBits(code) | ((op == 4'h3) ? B_SUB : 14'b0));
            end
            4'h4: begin
                n = 0;
                done = 1'b0;
                while (!done && n < 40) begin
                    if (holdEnter && n < 3) ent = 1'b1;
                    else if (n > 6)         ent = ~prevEnter;
                    else                    ent = randBit();
                    done = ent & ~prevEnter;
                    stepCheck("input", 4'($urandom), ent, 6,
                              aselBits(2'b01) | (done ? B_ALOAD : 14'b0));
                    n++;
                end
            end
            4'h7: begin
                for (int i = 0; i < 20; i++)
                    stepCheck("halt", 4'($urandom), ~prevEnter, 9, B_HALT);
                applyReset();
            end
            4'hE: stepCheck("output", 4'($urandom), randBit(), 8, B_OUTLOAD);
            default:
                if (taken)
                    stepCheck("jump", 4'($urandom), randBit(), 7, B_JMPMUX | B_PCLOAD);
        endcase
    endtask

    initial begin
        bus.Enter = 1'b0;
        bus.IR    = 4'h0;
        bus.Aeq0  = 1'b0;
        bus.Apos  = 1'b0;

        $display("[TB] directed sequence");
        applyReset();
        doInstr(4'h0, -1, 1'b0);
        doInstr(4'h5, 1, 1'b0);
        doInstr(4'h5, 0, 1'b0);
        doInstr(4'h6, 2, 1'b0);
        doInstr(4'h6, 1, 1'b0);
        doInstr(4'h9, 0, 1'b0);
        doInstr(4'h9, 1, 1'b0);
        doInstr(4'h8, 1, 1'b0);
        doInstr(4'h4, -1, 1'b1);
        doInstr(4'hA, -1, 1'b0);
        doInstr(4'hB, -1, 1'b0);
        doInstr(4'hC, -1, 1'b0);
        doInstr(4'hD, -1, 1'b0);
        doInstr(4'h3, -1, 1'b0);
        doInstr(4'h2, -1, 1'b0);
        doInstr(4'hE, -1, 1'b0);
        doInstr(4'hF, -1, 1'b0);
        doInstr(4'h1, -1, 1'b0);

        $display("[TB] reset during STORE");
        fetchDecode(4'h1, 1'b0, 1'b0, 1'b0);
        stepCheck("store", 4'h0, 1'b0, 4, B_MEMINST | B_MEMWR);
        applyReset();
        doInstr(4'h0, -1, 1'b0);

        $display("[TB] random opcodes");
        for (int k = 0; k < 150; k++)
            doInstr(4'($urandom_range(0, 15)), -1, 1'($urandom_range(0, 1)));

        $display("[TB] halt and recovery");
        doInstr(4'h7, -1, 1'b0);
        doInstr(4'h0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
